// File: rtl/hwpe_stream_tcdm_rr_arbiter.sv
// rtl/hwpe_stream_tcdm_rr_arbiter.sv - round-robin TCDM arbiter with in-order read response steering
module hwpe_stream_tcdm_rr_arbiter #(
    parameter int NB_IN           = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic [NB_IN-1:0]    in_req_i,
    output logic [NB_IN-1:0]    in_gnt_o,
    input  logic [NB_IN*32-1:0] in_add_i,
    input  logic [NB_IN-1:0]    in_wen_i,
    input  logic [NB_IN*4-1:0]  in_be_i,
    input  logic [NB_IN*32-1:0] in_data_i,
    output logic [NB_IN*32-1:0] in_r_data_o,
    output logic [NB_IN-1:0]    in_r_valid_o,
    output logic                out_req_o,
    input  logic                out_gnt_i,
    output logic [31:0]         out_add_o,
    output logic                out_wen_o,
    output logic [3:0]          out_be_o,
    output logic [31:0]         out_data_o,
    input  logic [31:0]         out_r_data_i,
    input  logic                out_r_valid_i,
    output logic                busy_o,
    output logic                err_o
);

    localparam int ID_W  = (NB_IN > 1) ? $clog2(NB_IN) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [ID_W-1:0]  rr_ptr_q;
    logic [ID_W-1:0]  id_fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    logic [ID_W-1:0]  winner;
    logic [ID_W-1:0]  scan_idx;
    logic [ID_W-1:0]  head_id;
    logic             found;
    logic             stall;
    logic             hs;
    logic             push;
    logic             pop;
    int               scan_sum;

    // Pick the first requester at or after rr_ptr, wrapping modulo NB_IN
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_idx = '0;
        scan_sum = 0;
        for (int k = 0; k < NB_IN; k++) begin
            scan_sum = int'(rr_ptr_q) + k;
            if (scan_sum >= NB_IN) begin
                scan_sum = scan_sum - NB_IN;
            end
            scan_idx = ID_W'(scan_sum);
            if (!found && in_req_i[scan_idx]) begin
                winner = scan_idx;
                found  = 1'b1;
            end
        end
    end

    // A full ID FIFO blocks every new request; a same-cycle pop is not considered
    assign stall     = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign out_req_o = (|in_req_i) & ~stall;
    assign hs        = out_req_o & out_gnt_i;
    assign push      = hs & in_wen_i[winner];
    assign pop       = out_r_valid_i & (cnt_q != '0);
    assign head_id   = id_fifo_q[head_q];

    // Steer the winner's request fields; lane 0 when idle since they are don't-care then
    always_comb begin
        out_add_o  = in_add_i[31:0];
        out_wen_o  = in_wen_i[0];
        out_be_o   = in_be_i[3:0];
        out_data_o = in_data_i[31:0];
        for (int i = 0; i < NB_IN; i++) begin
            if (winner == ID_W'(i)) begin
                out_add_o  = in_add_i[i*32 +: 32];
                out_wen_o  = in_wen_i[i];
                out_be_o   = in_be_i[i*4 +: 4];
                out_data_o = in_data_i[i*32 +: 32];
            end
        end
    end

    // Grant back to the winner and response valid to the FIFO head, both zero-latency
    always_comb begin
        in_gnt_o     = '0;
        in_r_valid_o = '0;
        for (int i = 0; i < NB_IN; i++) begin
            in_gnt_o[i]     = hs  && (winner  == ID_W'(i));
            in_r_valid_o[i] = pop && (head_id == ID_W'(i));
        end
    end

    assign in_r_data_o = {NB_IN{out_r_data_i}};
    assign busy_o      = (|in_req_i) | (cnt_q != '0);
    assign err_o       = err_q;

    // Arbitration pointer, read-ID FIFO and sticky protocol error
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                id_fifo_q[i] <= '0;
            end
        end else if (clear_i) begin
            rr_ptr_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                id_fifo_q[i] <= '0;
            end
        end else begin
            if (hs) begin
                rr_ptr_q <= (winner == ID_W'(NB_IN - 1)) ? '0 : winner + 1'b1;
            end
            if (push) begin
                id_fifo_q[tail_q] <= winner;
                tail_q <= (tail_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : tail_q + 1'b1;
            end
            if (pop) begin
                head_q <= (head_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : head_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (out_r_valid_i && (cnt_q == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hwpe_stream_tcdm_rr_arbiter.sv
// tb/tb_hwpe_stream_tcdm_rr_arbiter.sv - scoreboard bench for the round-robin TCDM arbiter
module tb_hwpe_stream_tcdm_rr_arbiter;

    localparam int NB_IN = 4;
    localparam int MAX_OUTSTANDING = 2;

    logic                clk_i = 1'b0;
    logic                rst_i = 1'b1;
    logic                clear_i = 1'b0;
    logic [NB_IN-1:0]    in_req_i = '0;
    logic [NB_IN-1:0]    in_gnt_o;
    logic [NB_IN*32-1:0] in_add_i = '0;
    logic [NB_IN-1:0]    in_wen_i = '0;
    logic [NB_IN*4-1:0]  in_be_i = '0;
    logic [NB_IN*32-1:0] in_data_i = '0;
    logic [NB_IN*32-1:0] in_r_data_o;
    logic [NB_IN-1:0]    in_r_valid_o;
    logic                out_req_o;
    logic                out_gnt_i = 1'b0;
    logic [31:0]         out_add_o;
    logic                out_wen_o;
    logic [3:0]          out_be_o;
    logic [31:0]         out_data_o;
    logic [31:0]         out_r_data_i = '0;
    logic                out_r_valid_i = 1'b0;
    logic                busy_o;
    logic                err_o;

    int errors = 0;
    int checks = 0;
    int resp_q[$];
    int grant_q[$];

    hwpe_stream_tcdm_rr_arbiter #(
        .NB_IN(NB_IN),
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .clear_i(clear_i),
        .in_req_i(in_req_i),
        .in_gnt_o(in_gnt_o),
        .in_add_i(in_add_i),
        .in_wen_i(in_wen_i),
        .in_be_i(in_be_i),
        .in_data_i(in_data_i),
        .in_r_data_o(in_r_data_o),
        .in_r_valid_o(in_r_valid_o),
        .out_req_o(out_req_o),
        .out_gnt_i(out_gnt_i),
        .out_add_o(out_add_o),
        .out_wen_o(out_wen_o),
        .out_be_o(out_be_o),
        .out_data_o(out_data_o),
        .out_r_data_i(out_r_data_i),
        .out_r_valid_i(out_r_valid_i),
        .busy_o(busy_o),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lane_add(input int i);
        return 32'hA000_0000 + 32'(i * 16);
    endfunction

    function automatic logic [31:0] lane_data(input int i);
        return 32'hD000_0000 + 32'(i * 257);
    endfunction

    task automatic set_lane(input int i, input logic wen);
        in_add_i[i*32 +: 32] = lane_add(i);
        in_data_i[i*32 +: 32] = lane_data(i);
        in_be_i[i*4 +: 4] = 4'(4'hF ^ i);
        in_wen_i[i] = wen;
    endtask

    // Pop the expected responder (none if queue empty) and compare with the DUT
    task automatic check_resp(input string tag);
        logic [NB_IN-1:0] exp_v;
        exp_v = '0;
        if (resp_q.size() > 0) exp_v = NB_IN'(1) << resp_q.pop_front();
        chk(tag, in_r_valid_o, exp_v);
        chk({tag, "_data"}, in_r_data_o, {NB_IN{out_r_data_i}});
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_state();
        in_req_i = '0;
        out_gnt_i = 1'b0;
        out_r_valid_i = 1'b0;
        clear_i = 1'b1;
        next_cycle();
        clear_i = 1'b0;
        resp_q.delete();
    endtask

    initial begin
        int g;
        #3;
        chk("rst_gnt", in_gnt_o, 0);
        chk("rst_rvalid", in_r_valid_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_req", out_req_o, 0);
        next_cycle();
        rst_i = 1'b0;

        // 1) all lanes read, one-cycle memory latency
        clear_state();
        for (int i = 0; i < NB_IN; i++) set_lane(i, 1'b1);
        grant_q = '{0, 1, 2, 3, 0};
        out_gnt_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_req_i = (c < 5) ? 4'hF : 4'h0;
            out_r_valid_i = (c > 0);
            out_r_data_i = 32'hBEEF_0000 + 32'(c);
            @(negedge clk_i);
            if (c > 0) check_resp("t1_rvalid");
            if (c < 5) begin
                g = grant_q.pop_front();
                chk("t1_gnt", in_gnt_o, NB_IN'(1) << g);
                chk("t1_add", out_add_o, lane_add(g));
                chk("t1_be", out_be_o, 4'(4'hF ^ g));
                resp_q.push_back(g);
            end
            next_cycle();
        end
        out_r_valid_i = 1'b0;
        @(negedge clk_i);
        chk("t1_idle_busy", busy_o, 0);
        next_cycle();

        // 2) lane 2 alone, memory withholds gnt for three cycles
        clear_state();
        in_req_i = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            chk("t2_req", out_req_o, 1);
            chk("t2_gnt_wait", in_gnt_o, 0);
            chk("t2_add", out_add_o, lane_add(2));
            next_cycle();
        end
        out_gnt_i = 1'b1;
        @(negedge clk_i);
        chk("t2_gnt", in_gnt_o, 4'b0100);
        resp_q.push_back(2);
        next_cycle();
        chk("t2_rrptr", dut.rr_ptr_q, 3);
        in_req_i = '0;
        out_gnt_i = 1'b0;
        out_r_valid_i = 1'b1;
        out_r_data_i = 32'h1234_5678;
        @(negedge clk_i);
        check_resp("t2_rvalid");
        next_cycle();
        out_r_valid_i = 1'b0;

        // 3) outstanding limit, responses delayed five cycles
        clear_state();
        in_req_i = 4'b0011;
        out_gnt_i = 1'b1;
        @(negedge clk_i);
        chk("t3_gnt0", in_gnt_o, 4'b0001);
        resp_q.push_back(0);
        next_cycle();
        @(negedge clk_i);
        chk("t3_gnt1", in_gnt_o, 4'b0010);
        resp_q.push_back(1);
        next_cycle();
        for (int c = 2; c < 5; c++) begin
            @(negedge clk_i);
            chk("t3_stall_req", out_req_o, 0);
            chk("t3_stall_gnt", in_gnt_o, 0);
            chk("t3_cnt", dut.cnt_q, 2);
            next_cycle();
        end
        out_r_valid_i = 1'b1;
        out_r_data_i = 32'h0000_AAAA;
        @(negedge clk_i);
        check_resp("t3_rvalid0");
        chk("t3_pop_stall", out_req_o, 0);
        next_cycle();
        out_r_data_i = 32'h0000_BBBB;
        @(negedge clk_i);
        check_resp("t3_rvalid1");
        chk("t3_resume_req", out_req_o, 1);
        chk("t3_resume_gnt", in_gnt_o, 4'b0001);
        resp_q.push_back(0);
        next_cycle();
        in_req_i = '0;
        out_r_data_i = 32'h0000_CCCC;
        @(negedge clk_i);
        check_resp("t3_rvalid2");
        next_cycle();
        out_r_valid_i = 1'b0;
        chk("t3_cnt_end", dut.cnt_q, 0);

        // 4) writes alternate, never allocate a response
        clear_state();
        set_lane(0, 1'b0);
        set_lane(1, 1'b0);
        in_req_i = 4'b0011;
        out_gnt_i = 1'b1;
        grant_q = '{0, 1, 0, 1};
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            g = grant_q.pop_front();
            chk("t4_gnt", in_gnt_o, NB_IN'(1) << g);
            chk("t4_wen", out_wen_o, 0);
            chk("t4_data", out_data_o, lane_data(g));
            chk("t4_rvalid", in_r_valid_o, 0);
            chk("t4_cnt", dut.cnt_q, 0);
            next_cycle();
        end

        // 5) stray response sets sticky error until clear
        clear_state();
        out_r_valid_i = 1'b1;
        @(negedge clk_i);
        chk("t5_rvalid", in_r_valid_o, 0);
        next_cycle();
        out_r_valid_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("t5_err_hold", err_o, 1);
            next_cycle();
        end
        clear_i = 1'b1;
        next_cycle();
        clear_i = 1'b0;
        chk("t5_err_clr", err_o, 0);

        // 6) asynchronous reset with one read outstanding
        clear_state();
        for (int i = 0; i < NB_IN; i++) set_lane(i, 1'b1);
        in_req_i = 4'hF;
        out_gnt_i = 1'b1;
        @(negedge clk_i);
        chk("t6_gnt", in_gnt_o, 4'b0001);
        next_cycle();
        chk("t6_cnt_pre", dut.cnt_q, 1);
        out_r_valid_i = 1'b1;
        rst_i = 1'b1;
        #1;
        resp_q.delete();
        chk("t6_cnt_rst", dut.cnt_q, 0);
        chk("t6_ptr_rst", dut.rr_ptr_q, 0);
        chk("t6_rvalid_rst", in_r_valid_o, 0);
        next_cycle();
        rst_i = 1'b0;
        in_req_i = '0;
        @(negedge clk_i);
        chk("t6_late_rvalid", in_r_valid_o, 0);
        next_cycle();
        out_r_valid_i = 1'b0;
        chk("t6_err", err_o, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
